// File: rtl/bram_line_reader_pkg.sv
// -----------------------------------------------------------------------------
// bram_line_reader_pkg
// Shared types and default sizes for the BRAM line reader slice.
//   state_t          : reader FSM states (IDLE, READ, DRAIN)
//   DEF_ADDR_BITS    : default BRAM address width (addresses wrap modulo 2**n)
//   DEF_DATA_W       : default pixel width (RGB 8:8:8)
//   DEF_LEN_BITS     : default width of the line length field
// -----------------------------------------------------------------------------
package bram_line_reader_pkg;

    localparam int DEF_ADDR_BITS = 11;
    localparam int DEF_DATA_W    = 24;
    localparam int DEF_LEN_BITS  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/bram_line_reader_if.sv
// -----------------------------------------------------------------------------
// bram_line_reader_if
// Pixel stream (valid/ready with last flag) leaving the line reader.
//   m_data  : pixel value
//   m_valid : pixel valid
//   m_ready : downstream accept
//   m_last  : final pixel of the line
// Modports: master (reader side), slave (datapath side).
// -----------------------------------------------------------------------------
interface bram_line_reader_if #(
    parameter int DATA_W = bram_line_reader_pkg::DEF_DATA_W
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bram_line_reader_addr_gen.sv
// -----------------------------------------------------------------------------
// line_addr_gen
// Address/length sequencer for one line read.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture base/len/mirror for a new line
//   base, len  : first address and pixel count
//   mirror     : 1 = walk from base+len-1 down to base, 0 = walk upward
//   step       : one address has been issued; advance
//   addr       : address to issue now
//   remaining  : pixels not yet issued (including addr)
//   is_last    : addr is the final address of the line
// -----------------------------------------------------------------------------
module line_addr_gen #(
    parameter int ADDR_BITS = 11,
    parameter int LEN_BITS  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] base,
    input  logic [LEN_BITS-1:0]  len,
    input  logic                 mirror,
    input  logic                 step,
    output logic [ADDR_BITS-1:0] addr,
    output logic [LEN_BITS-1:0]  remaining,
    output logic                 is_last
);

    logic [ADDR_BITS-1:0] cur_r;
    logic [LEN_BITS-1:0]  rem_r;
    logic                 dir_r;

    // Address counter, remaining count and walk direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r <= {ADDR_BITS{1'b0}};
            rem_r <= {LEN_BITS{1'b0}};
            dir_r <= 1'b0;
        end else if (load) begin
            dir_r <= mirror;
            rem_r <= len;
            // Mirrored lines start at the far end; truncation gives the modulo wrap.
            cur_r <= mirror ? (base + ADDR_BITS'(len) - ADDR_BITS'(1'b1)) : base;
        end else if (step) begin
            cur_r <= dir_r ? (cur_r - ADDR_BITS'(1'b1)) : (cur_r + ADDR_BITS'(1'b1));
            rem_r <= rem_r - LEN_BITS'(1'b1);
        end else begin
            cur_r <= cur_r;
            rem_r <= rem_r;
            dir_r <= dir_r;
        end
    end

    assign addr      = cur_r;
    assign remaining = rem_r;
    assign is_last   = (rem_r == LEN_BITS'(1'b1));

endmodule

// File: rtl/bram_line_reader.sv
// -----------------------------------------------------------------------------
// bram_line_reader
// Port-B read master for the pixel BRAM: on start, streams line_len pixels from
// base_addr as a valid/ready stream with a last flag, at 1 pixel/clk. The BRAM
// read enable doubles as the stall: the registered BRAM output holds while
// mem_en is low, so no skid buffer is needed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : 1-cycle command, honoured only while busy==0
//   base_addr, line_len : line description, sampled with start
//   mirror              : (BRAM_LINE_READER_MIRROR_EN builds only) reverse walk
//   busy                : line in progress
//   done                : 1-cycle pulse at line end or for a zero-length command
//   mem_addr, mem_en    : BRAM port-B address and read/advance strobe
//   mem_wr              : BRAM write enable, always 0
//   mem_data            : BRAM read data (1-cycle registered latency)
//   m                   : pixel stream (master modport)
// Build option: define BRAM_LINE_READER_MIRROR_EN to add the mirror input.
// -----------------------------------------------------------------------------
module bram_line_reader
    import bram_line_reader_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEN_BITS  = DEF_LEN_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]  line_len,
`ifdef BRAM_LINE_READER_MIRROR_EN
    input  logic                 mirror,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_en,
    output logic                 mem_wr,
    input  logic [DATA_W-1:0]    mem_data,
    bram_line_reader_if.master   m
);

    state_t state_r, state_nx;
    logic   m_valid_r, valid_nx;
    logic   last_q_r, last_nx;
    logic   done_r, done_nx;
    logic   adv_s, load_s, step_s, mem_en_s, mirror_s, is_last_s;
    logic [LEN_BITS-1:0] remaining_s;

`ifdef BRAM_LINE_READER_MIRROR_EN
    assign mirror_s = mirror;
`else
    assign mirror_s = 1'b0;
`endif

    line_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .LEN_BITS  (LEN_BITS)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .base      (base_addr),
        .len       (line_len),
        .mirror    (mirror_s),
        .step      (step_s),
        .addr      (mem_addr),
        .remaining (remaining_s),
        .is_last   (is_last_s)
    );

    // The output slot can take a new pixel when empty or being consumed.
    assign adv_s = !m_valid_r || m.m_ready;

    // Next-state, BRAM strobe and stream flag decode.
    always_comb begin
        state_nx = state_r;
        valid_nx = m_valid_r;
        last_nx  = last_q_r;
        done_nx  = 1'b0;
        load_s   = 1'b0;
        step_s   = 1'b0;
        mem_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (line_len != {LEN_BITS{1'b0}}) begin
                        load_s   = 1'b1;
                        state_nx = READ;
                    end else begin
                        done_nx  = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            READ: begin
                if (adv_s) begin
                    mem_en_s = 1'b1;
                    step_s   = 1'b1;
                    valid_nx = 1'b1;
                    last_nx  = is_last_s;
                    if (is_last_s) begin
                        state_nx = DRAIN;
                    end else begin
                        state_nx = READ;
                    end
                end else begin
                    state_nx = READ;
                end
            end
            DRAIN: begin
                // Advancing here with m_valid set is the handshake of the last beat.
                if (adv_s) begin
                    mem_en_s = 1'b1;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                    done_nx  = m_valid_r;
                    state_nx = IDLE;
                end else begin
                    state_nx = DRAIN;
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                last_nx  = 1'b0;
            end
        endcase
    end

    // FSM state, stream flags and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            m_valid_r <= 1'b0;
            last_q_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx;
            m_valid_r <= valid_nx;
            last_q_r  <= last_nx;
            done_r    <= done_nx;
        end
    end

    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign mem_en    = mem_en_s;
    assign mem_wr    = 1'b0;
    assign m.m_data  = mem_data;
    assign m.m_valid = m_valid_r;
    assign m.m_last  = m_valid_r & last_q_r;

endmodule

// File: tb/tb_bram_line_reader.sv
module tb_bram_line_reader;
    import bram_line_reader_pkg::*;

    localparam int AW = DEF_ADDR_BITS;
    localparam int DW = DEF_DATA_W;
    localparam int LW = DEF_LEN_BITS;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] line_len = '0;
`ifdef BRAM_LINE_READER_MIRROR_EN
    logic          mirror = 1'b0;
`endif
    logic          busy, done, mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    bram_line_reader_if #(.DATA_W(DW)) sif ();

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   done_cnt = 0, beat_cnt = 0, valid_cnt = 0;
    int   first_cyc = -1, last_cyc = -1, done_cyc = -1;
    exp_t exp_q[$];
    logic hold = 1'b0;
    logic [DW-1:0] held = '0;
    logic [3:0] ready_pat = 4'b1001;

    bram_line_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .line_len  (line_len),
`ifdef BRAM_LINE_READER_MIRROR_EN
        .mirror    (mirror),
`endif
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_data  (mem_data),
        .m         (sif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read BRAM model: output holds while mem_en is low.
    always @(posedge clk) begin
        if (mem_en) mem_data <= mem[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference addresses: base+i (or base+len-1-i mirrored), modulo 2**AW.
    task automatic push_line(input int base, input int len, input bit mir);
        exp_t e;
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = mir ? AW'(base + len - 1 - i) : AW'(base + i);
            e.data  = DW'(int'(a) * 3);
            e.last  = (i == len - 1);
            e.first = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int base, input int len, input bit mir, output int c0);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = AW'(base);
        line_len  = LW'(len);
`ifdef BRAM_LINE_READER_MIRROR_EN
        mirror    = mir;
`endif
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int d0, input bit tog, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk); #1;
            if (tog) sif.m_ready = ready_pat[n % 4];
            n++;
        end
        if (done_cnt == d0) check_val("done_timeout", 32'd0, 32'd1);
        sif.m_ready = 1'b1;
    endtask

    // Monitor: scoreboard compare, backpressure stability, done/valid tracking.
    always @(negedge clk) begin
        exp_t e;
        if (sif.m_valid === 1'b1) valid_cnt++;
        if (hold) begin
            check_val("hold_valid", 32'(sif.m_valid), 32'd1);
            check_val("hold_data", 32'(sif.m_data), 32'(held));
        end
        hold = !rst && (sif.m_valid === 1'b1) && (sif.m_ready === 1'b0);
        held = sif.m_data;
        if (sif.m_valid === 1'b1 && sif.m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("beat_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("beat_data", 32'(sif.m_data), 32'(e.data));
                check_val("beat_last", 32'(sif.m_last), 32'(e.last));
                if (e.first) first_cyc = cyc;
                last_cyc = cyc;
            end
            beat_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst) exp_q.delete();
    end

    initial begin
        int c0, d0, b0, v0;
        for (int k = 0; k < (1 << AW); k++) mem[k] = DW'(k * 3);
        sif.m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_valid", 32'(sif.m_valid), 32'd0);
        check_val("rst_last", 32'(sif.m_last), 32'd0);
        check_val("rst_mem_en", 32'(mem_en), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_mem_wr", 32'(mem_wr), 32'd0);
        rst = 1'b0;

        // 1: base 10, len 8, full throughput
        d0 = done_cnt; b0 = beat_cnt;
        push_line(10, 8, 1'b0);
        do_start(10, 8, 1'b0, c0);
        check_val("t1_busy_c1", 32'(busy), 32'd1);
        run_until_done(d0, 1'b0, 100);
        check_val("t1_first_cyc", 32'(first_cyc), 32'(c0 + 2));
        check_val("t1_last_cyc", 32'(last_cyc), 32'(c0 + 9));
        check_val("t1_done_cyc", 32'(done_cyc), 32'(c0 + 10));
        check_val("t1_beats", 32'(beat_cnt - b0), 32'd8);
        check_val("t1_busy_end", 32'(busy), 32'd0);

        // 2: same line under toggling backpressure
        d0 = done_cnt; b0 = beat_cnt;
        push_line(10, 8, 1'b0);
        do_start(10, 8, 1'b0, c0);
        run_until_done(d0, 1'b1, 200);
        check_val("t2_beats", 32'(beat_cnt - b0), 32'd8);
        check_val("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: address wrap
        d0 = done_cnt; b0 = beat_cnt;
        push_line(2046, 4, 1'b0);
        do_start(2046, 4, 1'b0, c0);
        run_until_done(d0, 1'b0, 100);
        check_val("t3_beats", 32'(beat_cnt - b0), 32'd4);

        // 4: zero length, then single pixel
        d0 = done_cnt; v0 = valid_cnt;
        do_start(20, 0, 1'b0, c0);
        check_val("t4_len0_done", 32'(done), 32'd1);
        check_val("t4_len0_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_val("t4_len0_done_once", 32'(done), 32'd0);
        check_val("t4_len0_busy2", 32'(busy), 32'd0);
        check_val("t4_len0_novalid", 32'(valid_cnt - v0), 32'd0);
        check_val("t4_len0_cnt", 32'(done_cnt - d0), 32'd1);
        d0 = done_cnt; b0 = beat_cnt;
        push_line(40, 1, 1'b0);
        do_start(40, 1, 1'b0, c0);
        run_until_done(d0, 1'b0, 50);
        check_val("t4_len1_beats", 32'(beat_cnt - b0), 32'd1);
        check_val("t4_len1_done_cyc", 32'(done_cyc), 32'(c0 + 3));

        // 5a: reset on the 3rd of 8 beats aborts without done
        d0 = done_cnt; b0 = beat_cnt;
        push_line(10, 8, 1'b0);
        do_start(10, 8, 1'b0, c0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("t5_abort_valid", 32'(sif.m_valid), 32'd0);
        check_val("t5_abort_busy", 32'(busy), 32'd0);
        check_val("t5_abort_mem_en", 32'(mem_en), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check_val("t5_abort_nodone", 32'(done_cnt - d0), 32'd0);
        check_val("t5_abort_beats", 32'(beat_cnt - b0), 32'd3);

        // 5b: new line after reset; start while busy is ignored
        d0 = done_cnt; b0 = beat_cnt;
        push_line(100, 8, 1'b0);
        do_start(100, 8, 1'b0, c0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(500); line_len = LW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(d0, 1'b0, 100);
        repeat (10) @(posedge clk);
        #1;
        check_val("t5_busy_beats", 32'(beat_cnt - b0), 32'd8);
        check_val("t5_busy_done", 32'(done_cnt - d0), 32'd1);
        check_val("t5_busy_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef BRAM_LINE_READER_MIRROR_EN
        // 6: mirrored walk 13,12,11,10
        d0 = done_cnt; b0 = beat_cnt;
        push_line(10, 4, 1'b1);
        do_start(10, 4, 1'b1, c0);
        run_until_done(d0, 1'b0, 100);
        check_val("t6_beats", 32'(beat_cnt - b0), 32'd4);
        check_val("t6_q_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
